// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or address decoder plus master) and
// the SRAM subordinate. Carries address/control, write data, and the
// subordinate's ready/response/read-data return path.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate serving single-beat transfers from a 2^ADDR_WIDTH x 32 word memory.
// Latency: OKAY data phase = WAIT_STATES+1 cycles, ERROR data phase = 2 cycles.
// Backpressure: HREADYOUT low during wait states and the first ERROR cycle; new address phases only taken when HREADY is high.
// Ports: HCLK/HRESETn plain; bus = slave modport carrying HSEL/HADDR/HWRITE/HSIZE/HTRANS/HREADY/HWDATA in,
//        HREADYOUT/HRESP/HRDATA out. HBURST, HPROT, HMASTLOCK are accepted but have no effect.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_sram_slave_if.slave    bus
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                  state, next_state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    write_q;
    logic [31:0]             hrdata_q;
    logic                    hreadyout;
    logic                    hresp;

    logic [31:0]             mem [DEPTH];

    logic                    accept;
    logic                    illegal;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic [3:0]              wr_lanes;
    logic [31:0]             wr_word;
    logic [31:0]             rd_word;
    logic                    rd_entry;

    function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] en;
        case (sz)
            2'd0:    en = 4'b0001 << a;
            2'd1:    en = a[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    // An address phase can only be taken in a cycle where this slave is
    // itself ready (no data phase stalled), in addition to the bus HREADY.
    assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] &&
                    (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

    assign illegal = (bus.HSIZE > 3'd2) ||
                     (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
                     (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_WAIT: next_state = (cnt == WS) ? ST_DATA : ST_WAIT;
            ST_ERR1: next_state = ST_ERR2;
            default: begin
                if (accept) begin
                    if (illegal)          next_state = ST_ERR1;
                    else if (WS != 4'd0)  next_state = ST_WAIT;
                    else                  next_state = ST_DATA;
                end
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    // Address-phase capture and wait counter; cnt counts WAIT cycles from 1.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            cnt     <= 4'd0;
        end else begin
            if (accept) begin
                addr_q  <= bus.HADDR[ADDR_WIDTH+1:0];
                size_q  <= bus.HSIZE[1:0];
                write_q <= bus.HWRITE;
                cnt     <= 4'd1;
            end else if (state == ST_WAIT && cnt != WS) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Write commits on the edge that ends the DATA cycle. Because DATA is
    // gated by the asynchronously reset state, a reset drops pending writes.
    assign commit   = (state == ST_DATA) && write_q;
    assign wr_idx   = addr_q[ADDR_WIDTH+1:2];
    assign wr_lanes = lane_en(size_q, addr_q[1:0]);

    always_comb begin
        wr_word = mem[wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_lanes[b]) wr_word[b*8 +: 8] = bus.HWDATA[b*8 +: 8];
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) mem[wr_idx] <= wr_word;
    end

    // Entry into DATA comes either from WAIT (registered transfer) or, with
    // zero wait states, straight from the address phase on the bus.
    assign rd_entry = (next_state == ST_DATA) &&
                      ((state == ST_WAIT) ? !write_q : !bus.HWRITE);
    assign rd_idx   = (state == ST_WAIT) ? addr_q[ADDR_WIDTH+1:2]
                                         : bus.HADDR[ADDR_WIDTH+1:2];

    // Pipelined write-then-read to the same word: forward the merged word.
    assign rd_word = (commit && wr_idx == rd_idx) ? wr_word : mem[rd_idx];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hrdata_q <= 32'h0;
        end else if (rd_entry) begin
            hrdata_q <= rd_word;
        end
    end

    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;
    assign bus.HRDATA    = hrdata_q;

    logic unused_ok;
    assign unused_ok = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HBURST, bus.HPROT, bus.HMASTLOCK};

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

    logic HCLK = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus1 ();

    // Single-slave bus: the bus-level HREADY is this slave's own HREADYOUT.
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus1.HREADY = bus1.HREADYOUT;

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(rst0), .bus(bus0)
    );
    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut1 (
        .HCLK(HCLK), .HRESETn(rst1), .bus(bus1)
    );

    localparam int WS1 = 1;

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the transfer finished.
    task automatic xfer1(input vec_t v, output int lowc, output logic resp_first,
                         output logic resp_last, output logic [31:0] rd, output logic timeout);
        bus1.HSEL   = 1'b1;
        bus1.HTRANS = 2'b10;
        bus1.HADDR  = v.addr;
        bus1.HWRITE = v.wr;
        bus1.HSIZE  = v.sz;
        @(posedge HCLK);
        @(negedge HCLK);
        bus1.HSEL   = 1'b0;
        bus1.HTRANS = 2'b00;
        bus1.HWDATA = v.wr ? v.wdata : 32'h0;
        lowc        = 0;
        timeout     = 1'b1;
        resp_first  = bus1.HRESP;
        resp_last   = bus1.HRESP;
        for (int c = 0; c < 20; c++) begin
            resp_last = bus1.HRESP;
            if (bus1.HREADYOUT) begin
                timeout = 1'b0;
                break;
            end
            lowc++;
            @(negedge HCLK);
        end
        rd = bus1.HRDATA;
        @(negedge HCLK);
    endtask

    task automatic drive_idle(input logic [31:0] dummy);
        bus0.HSEL = 1'b0; bus0.HTRANS = 2'b00; bus0.HADDR = dummy; bus0.HWRITE = 1'b0;
        bus0.HSIZE = 3'd2; bus0.HWDATA = 32'h0;
        bus1.HSEL = 1'b0; bus1.HTRANS = 2'b00; bus1.HADDR = dummy; bus1.HWRITE = 1'b0;
        bus1.HSIZE = 3'd2; bus1.HWDATA = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lowc;
        logic        rf, rl, to;
        logic [31:0] rd;
        logic [31:0] exp_hr;

        //        wr    sz    addr          wdata          err   rdata
        vecs[0]  = '{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 3'd0, 32'h0000_0013, 32'hAA00_0000, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hAAAD_BEEF};
        vecs[4]  = '{1'b1, 3'd1, 32'h0000_0010, 32'h0000_1234, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hAAAD_1234};
        vecs[6]  = '{1'b0, 3'd2, 32'h0000_0002, 32'h0,         1'b1, 32'h0};
        vecs[7]  = '{1'b1, 3'd1, 32'h0000_0011, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hAAAD_1234};
        vecs[9]  = '{1'b0, 3'd0, 32'h0000_0013, 32'h0,         1'b0, 32'hAAAD_1234};
        vecs[10] = '{1'b1, 3'd3, 32'h0000_0020, 32'h5555_5555, 1'b1, 32'h0};

        bus0.HBURST = 3'd0; bus0.HPROT = 4'h3; bus0.HMASTLOCK = 1'b0;
        bus1.HBURST = 3'd0; bus1.HPROT = 4'h3; bus1.HMASTLOCK = 1'b0;
        drive_idle(32'h0);

        // Reset values after a few clocks with reset held low.
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst1_hreadyout", bus1.HREADYOUT, 1'b1);
        check("rst1_hresp",     bus1.HRESP,     1'b0);
        check("rst1_hrdata",    bus1.HRDATA,    32'h0);
        check("rst0_hreadyout", bus0.HREADYOUT, 1'b1);
        check("rst0_hrdata",    bus0.HRDATA,    32'h0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge HCLK);

        // Table-driven single transfers on the one-wait-state slave.
        exp_hr = 32'h0;
        for (int i = 0; i < 11; i++) begin
            xfer1(vecs[i], lowc, rf, rl, rd, to);
            if (!vecs[i].wr && !vecs[i].err) exp_hr = vecs[i].rdata;
            check($sformatf("vec%0d_timeout", i),    to,   1'b0);
            check($sformatf("vec%0d_low_cycles", i), lowc, vecs[i].err ? 32'd1 : 32'(WS1));
            check($sformatf("vec%0d_resp_first", i), rf,   vecs[i].err);
            check($sformatf("vec%0d_resp_last", i),  rl,   vecs[i].err);
            check($sformatf("vec%0d_hrdata", i),     rd,   exp_hr);
        end

        // IDLE, BUSY, and deselected NONSEQ write attempts must be ignored.
        for (int p = 0; p < 3; p++) begin
            bus1.HSEL   = (p == 2) ? 1'b0 : 1'b1;
            bus1.HTRANS = (p == 0) ? 2'b00 : (p == 1) ? 2'b01 : 2'b10;
            bus1.HADDR  = 32'h10;
            bus1.HWRITE = 1'b1;
            bus1.HSIZE  = 3'd2;
            bus1.HWDATA = 32'hFFFF_FFFF;
            repeat (2) begin
                @(negedge HCLK);
                check($sformatf("ignore%0d_hreadyout", p), bus1.HREADYOUT, 1'b1);
                check($sformatf("ignore%0d_hresp", p),     bus1.HRESP,     1'b0);
                check($sformatf("ignore%0d_hrdata", p),    bus1.HRDATA,    exp_hr);
            end
        end
        drive_idle(32'h0);
        @(negedge HCLK);
        xfer1('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h0}, lowc, rf, rl, rd, to);
        check("ignore_mem_unchanged", rd, 32'hAAAD_1234);

        // Reset asserted mid-WAIT of a write: outputs clear without a clock
        // edge and the write never lands.
        bus1.HSEL = 1'b1; bus1.HTRANS = 2'b10; bus1.HADDR = 32'h10;
        bus1.HWRITE = 1'b1; bus1.HSIZE = 3'd2;
        @(posedge HCLK);
        @(negedge HCLK);
        bus1.HSEL = 1'b0; bus1.HTRANS = 2'b00; bus1.HWDATA = 32'h5555_5555;
        check("midwait_hreadyout", bus1.HREADYOUT, 1'b0);
        #2 rst1 = 1'b0;
        #1;
        check("async_rst_hreadyout", bus1.HREADYOUT, 1'b1);
        check("async_rst_hresp",     bus1.HRESP,     1'b0);
        check("async_rst_hrdata",    bus1.HRDATA,    32'h0);
        @(negedge HCLK);
        rst1 = 1'b1;
        @(negedge HCLK);
        xfer1('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h0}, lowc, rf, rl, rd, to);
        check("rst_dropped_write", rd, 32'hAAAD_1234);

        // Zero-wait slave: back-to-back W(0x11111111), W(0xCAFEF00D), R to 0x20.
        // The read's DATA entry coincides with the second write's commit.
        bus0.HSEL = 1'b1; bus0.HTRANS = 2'b10; bus0.HADDR = 32'h20;
        bus0.HWRITE = 1'b1; bus0.HSIZE = 3'd2;
        @(posedge HCLK);
        @(negedge HCLK);
        check("ws0_w1_hreadyout", bus0.HREADYOUT, 1'b1);
        bus0.HWDATA = 32'h1111_1111;
        bus0.HTRANS = 2'b11;
        @(posedge HCLK);
        @(negedge HCLK);
        check("ws0_w2_hreadyout", bus0.HREADYOUT, 1'b1);
        bus0.HWDATA = 32'hCAFE_F00D;
        bus0.HWRITE = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        check("ws0_rd_hreadyout", bus0.HREADYOUT, 1'b1);
        check("ws0_rd_hresp",     bus0.HRESP,     1'b0);
        check("ws0_bypass_hrdata", bus0.HRDATA,   32'hCAFE_F00D);
        drive_idle(32'h0);
        @(negedge HCLK);
        check("ws0_idle_hreadyout", bus0.HREADYOUT, 1'b1);

        // Zero-wait slave: misaligned word read still takes two ERROR cycles.
        bus0.HSEL = 1'b1; bus0.HTRANS = 2'b10; bus0.HADDR = 32'h02;
        bus0.HWRITE = 1'b0; bus0.HSIZE = 3'd2;
        @(posedge HCLK);
        @(negedge HCLK);
        bus0.HSEL = 1'b0; bus0.HTRANS = 2'b00;
        check("ws0_err1_hreadyout", bus0.HREADYOUT, 1'b0);
        check("ws0_err1_hresp",     bus0.HRESP,     1'b1);
        @(negedge HCLK);
        check("ws0_err2_hreadyout", bus0.HREADYOUT, 1'b1);
        check("ws0_err2_hresp",     bus0.HRESP,     1'b1);
        check("ws0_err_hrdata_hold", bus0.HRDATA,   32'hCAFE_F00D);
        @(negedge HCLK);
        check("ws0_after_err_hresp", bus0.HRESP, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
